step_counter_matrix: RTL and testbench

Parametrised reversible step counter with load, modulo/saturate modes, an internal clock-enable prescaler and an 8-row history display driver. It is the next generation of the lab-4 top-level counter. It counts by a programmable step on every prescaled tick, keeps the last ROWS counter values in a shift buffer, and scans them onto the STRING/COLUMN LED-matrix outputs, one row per tick.

---
 rtl/step_counter_matrix.sv | 124 ++++++++++++
 tb/tb_step_counter_matrix.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/step_counter_matrix.sv
// Reversible step counter with load, wrap/saturate modes and a clock-enable prescaler.
// The last ROWS counter values are kept in a shift buffer and scanned onto an LED matrix.
module step_counter_matrix #(
  parameter int CLK_REF  = 48_000_000,
  parameter int CLK_CE   = 1_000_000,
  parameter int WIDTH    = 8,
  parameter int MOD      = 256,
  parameter int SAT_MODE = 0,
  parameter int ROWS     = 8
) (
  input  logic             clk,
  input  logic             btnCpuReset,
  input  logic             btnC,
  input  logic             btnU,
  input  logic [3:0]       STEP,
  input  logic             UP,
  output logic [7:0]       STRING,
  output logic [7:0]       COLUMN,
  output logic [WIDTH-1:0] CNT,
  output logic             TICK,
  output logic             WRAP
);

  localparam int DIV = CLK_REF / CLK_CE;
  localparam int PW  = $clog2(DIV);
  localparam int SW  = WIDTH + 1;
  localparam int RW  = $clog2(ROWS);
  localparam bit SAT = (SAT_MODE != 0);

  localparam logic [SW-1:0]    MOD_W    = SW'(MOD);
  localparam logic [SW-1:0]    MOD_M1   = SW'(MOD - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MOD - 1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(ROWS - 1);

  logic [PW-1:0]    pre_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hist_q [ROWS];
  logic [WIDTH-1:0] hist_d [ROWS];
  logic [RW-1:0]    row_q, row_d;
  logic [7:0]       string_q, string_d;
  logic [7:0]       column_q, column_d;
  logic             wrap_q, wrap_d;

  logic [SW-1:0]    step_x, cnt_x, up_sum;
  logic [WIDTH-1:0] stepped;
  logic             out_of_range;

  assign TICK   = (pre_q == PRE_LAST);
  assign CNT    = cnt_q;
  assign STRING = string_q;
  assign COLUMN = column_q;
  assign WRAP   = wrap_q;

  // Stepped value with wrap/clamp, all sums one bit wider than the counter.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    step_x       = (STEP == 4'd0) ? SW'(1) : SW'(STEP);
    cnt_x        = {1'b0, cnt_q};
    up_sum       = cnt_x + step_x;
    stepped      = cnt_q;
    out_of_range = 1'b0;
    if (UP) begin
      if (up_sum <= MOD_M1) begin
        stepped = WIDTH'(up_sum);
      end else begin
        out_of_range = 1'b1;
        stepped      = SAT ? CNT_MAX : WIDTH'(up_sum - MOD_W);
      end
    end else begin
      if (cnt_x >= step_x) begin
        stepped = WIDTH'(cnt_x - step_x);
      end else begin
        out_of_range = 1'b1;
        stepped      = SAT ? '0 : WIDTH'(cnt_x + MOD_W - step_x);
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    hist_d = hist_q;
    row_d  = row_q;
    wrap_d = 1'b0;
    if (TICK) begin
      row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      if (btnU) begin
        cnt_d = (SW'(STEP) > MOD_M1) ? CNT_MAX : WIDTH'(STEP);
      end else if (btnC) begin
        cnt_d  = stepped;
        wrap_d = out_of_range;
      end
      if (btnU || btnC) begin
        hist_d[0] = cnt_d;
        for (int i = 1; i < ROWS; i++) hist_d[i] = hist_q[i-1];
      end
    end
    // Display outputs are registered from next state so they move with the tick.
    string_d = 8'd1 << row_d;
    column_d = hist_d[row_d][7:0];
  end

  always_ff @(posedge clk) begin
    if (btnCpuReset) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      row_q    <= '0;
      string_q <= 8'h01;
      column_q <= 8'h00;
      wrap_q   <= 1'b0;
      // NOTE: the history drives the display directly, so it is cleared like ordinary state rather than left as uninitialised memory.
      for (int i = 0; i < ROWS; i++) hist_q[i] <= '0;
    end else begin
      pre_q    <= TICK ? '0 : pre_q + PW'(1);
      cnt_q    <= cnt_d;
      hist_q   <= hist_d;
      row_q    <= row_d;
      string_q <= string_d;
      column_q <= column_d;
      wrap_q   <= wrap_d;
    end
  end

endmodule

// File: tb/tb_step_counter_matrix.sv
// Bench for step_counter_matrix: a wrap-mode instance and a saturating 5-row instance
// share stimulus and are compared tick by tick against a plain-integer reference.
module tb_step_counter_matrix;

  localparam int DIV = 48;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btnC = 1'b0, btnU = 1'b0, UP = 1'b0;
  logic [3:0] STEP = 4'd0;

  logic [7:0] str_w, col_w, cnt_w, str_s, col_s, cnt_s;
  logic       tick_w, wrap_w, tick_s, wrap_s;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_tick = 0;
  logic last_wrap_w, last_wrap_s;

  // Reference state: index 0 = wrap instance, 1 = saturating instance.
  int m_mod  [2] = '{256, 200};
  bit m_sat  [2] = '{1'b0, 1'b1};
  int m_rows [2] = '{8, 5};
  int m_cnt  [2];
  int m_row  [2];
  bit m_wrap [2];
  int m_hist [2][8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  step_counter_matrix u_wrap (
    .clk(clk), .btnCpuReset(rst), .btnC(btnC), .btnU(btnU), .STEP(STEP), .UP(UP),
    .STRING(str_w), .COLUMN(col_w), .CNT(cnt_w), .TICK(tick_w), .WRAP(wrap_w)
  );

  step_counter_matrix #(.WIDTH(8), .MOD(200), .SAT_MODE(1), .ROWS(5)) u_sat (
    .clk(clk), .btnCpuReset(rst), .btnC(btnC), .btnU(btnU), .STEP(STEP), .UP(UP),
    .STRING(str_s), .COLUMN(col_s), .CNT(cnt_s), .TICK(tick_s), .WRAP(wrap_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]  = 0;
      m_row[k]  = 0;
      m_wrap[k] = 1'b0;
      for (int i = 0; i < 8; i++) m_hist[k][i] = 0;
    end
  endtask

  task automatic ref_tick(input int k, input bit u, input bit c, input int st, input bit up);
    int s;
    int v;
    s = (st == 0) ? 1 : st;
    m_wrap[k] = 1'b0;
    if (u) begin
      m_cnt[k] = (st < m_mod[k] - 1) ? st : m_mod[k] - 1;
    end else if (c) begin
      v = up ? m_cnt[k] + s : m_cnt[k] - s;
      if (v < 0 || v >= m_mod[k]) begin
        m_wrap[k] = 1'b1;
        if (m_sat[k]) v = (v < 0) ? 0 : m_mod[k] - 1;
        else          v = (v < 0) ? v + m_mod[k] : v - m_mod[k];
      end
      m_cnt[k] = v;
    end
    if (u || c) begin
      for (int i = m_rows[k] - 1; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
      m_hist[k][0] = m_cnt[k];
    end
    m_row[k] = (m_row[k] + 1) % m_rows[k];
  endtask

  task automatic check_dut(input int k, input logic [7:0] cnt, input logic [7:0] str,
                           input logic [7:0] col, input logic wrap);
    string p;
    p = (k == 0) ? "wrap_dut" : "sat_dut";
    chk({p, " CNT"},    {24'd0, cnt}, m_cnt[k]);
    chk({p, " STRING"}, {24'd0, str}, 1 << m_row[k]);
    chk({p, " COLUMN"}, {24'd0, col}, m_hist[k][m_row[k]] & 255);
    chk({p, " WRAP"},   {31'd0, wrap}, {31'd0, m_wrap[k]});
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    last_tick = cyc;
    ref_reset();
    check_dut(0, cnt_w, str_w, col_w, wrap_w);
    check_dut(1, cnt_s, str_s, col_s, wrap_s);
    chk("TICK in reset", {31'd0, tick_w}, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Scribbles on the inputs between ticks, presents the real values for the tick edge,
  // then checks the registered outputs after the edge and the WRAP drop one clk later.
  task automatic do_tick(input bit u, input bit c, input int st, input bit up);
    int n;
    n = 0;
    @(negedge clk);
    while (!tick_w && n < 4 * DIV) begin
      btnU = 1'($urandom);
      btnC = 1'($urandom);
      STEP = 4'($urandom);
      UP   = 1'($urandom);
      @(negedge clk);
      n++;
    end
    chk("tick seen", {31'd0, tick_w}, 1);
    chk("tick sat_dut aligned", {31'd0, tick_s}, 1);
    chk("CNT held between ticks", {24'd0, cnt_w}, m_cnt[0]);
    btnU = u;
    btnC = c;
    STEP = st[3:0];
    UP   = up;
    @(posedge clk);
    #1;
    chk("tick interval", cyc - last_tick, DIV);
    last_tick = cyc;
    ref_tick(0, u, c, st, up);
    ref_tick(1, u, c, st, up);
    check_dut(0, cnt_w, str_w, col_w, wrap_w);
    check_dut(1, cnt_s, str_s, col_s, wrap_s);
    last_wrap_w = wrap_w;
    last_wrap_s = wrap_s;
    @(posedge clk);
    #1;
    chk("WRAP one clk wrap_dut", {31'd0, wrap_w}, 0);
    chk("WRAP one clk sat_dut",  {31'd0, wrap_s}, 0);
    chk("TICK one clk", {31'd0, tick_w}, 0);
  endtask

  initial begin
    int r;
    bit ru, rc, rup;
    int rs;

    do_reset(2);

    // Idle: row select walks 01..80 and back to 01, counter stays 0.
    for (int t = 0; t < 9; t++) do_tick(1'b0, 1'b0, 0, 1'b1);
    chk("idle STRING after 9 ticks", {24'd0, str_w}, 8'h02);

    // Load 3, then count up by 3 four times.
    do_tick(1'b1, 1'b0, 3, 1'b1);
    for (int t = 0; t < 4; t++) do_tick(1'b0, 1'b1, 3, 1'b1);
    chk("up by 3 reaches 15", {24'd0, cnt_w}, 15);

    // Climb to 250, then wrap past 255.
    for (int t = 0; t < 15; t++) do_tick(1'b0, 1'b1, 15, 1'b1);
    do_tick(1'b0, 1'b1, 10, 1'b1);
    chk("climb to 250", {24'd0, cnt_w}, 250);
    do_tick(1'b0, 1'b1, 10, 1'b1);
    chk("250+10 wraps to 4", {24'd0, cnt_w}, 4);
    chk("wrap up pulse", {31'd0, last_wrap_w}, 1);

    // From 0, step 0 counts down by 1: wraps to 255, saturating copy clamps at 0.
    do_tick(1'b1, 1'b0, 0, 1'b0);
    do_tick(1'b0, 1'b1, 0, 1'b0);
    chk("0-1 wraps to 255", {24'd0, cnt_w}, 255);
    chk("wrap down pulse", {31'd0, last_wrap_w}, 1);
    chk("sat 0-1 clamps to 0", {24'd0, cnt_s}, 0);
    chk("sat clamp low pulse", {31'd0, last_wrap_s}, 1);

    // Saturate at MOD-1 = 199, and keep flagging on further attempts.
    do_tick(1'b1, 1'b0, 15, 1'b1);
    for (int t = 0; t < 13; t++) do_tick(1'b0, 1'b1, 15, 1'b1);
    chk("sat clamps at 199", {24'd0, cnt_s}, 199);
    chk("sat clamp high pulse", {31'd0, last_wrap_s}, 1);
    do_tick(1'b0, 1'b1, 15, 1'b1);
    chk("sat stays at 199", {24'd0, cnt_s}, 199);
    chk("sat repeated pulse", {31'd0, last_wrap_s}, 1);

    // Down from 5 by 9.
    do_tick(1'b1, 1'b0, 5, 1'b0);
    do_tick(1'b0, 1'b1, 9, 1'b0);
    chk("sat 5-9 clamps to 0", {24'd0, cnt_s}, 0);
    chk("wrap 5-9 gives 252", {24'd0, cnt_w}, 252);

    // Load and count on the same tick: load wins.
    do_tick(1'b1, 1'b1, 7, 1'b1);
    chk("load beats count", {24'd0, cnt_w}, 7);

    // Randomised traffic.
    for (int t = 0; t < 150; t++) begin
      r   = int'($urandom_range(0, 9));
      ru  = (r == 0);
      rc  = (r >= 3);
      rs  = int'($urandom_range(0, 15));
      rup = ($urandom_range(0, 3) != 0) ^ (t >= 75);
      do_tick(ru, rc, rs, rup);
    end

    // Mid-period reset: state clears and the cadence restarts from zero.
    repeat (17) @(posedge clk);
    do_reset(1);
    for (int t = 0; t < 3; t++) do_tick(1'b0, 1'b1, 2, 1'b1);
    chk("count after reset", {24'd0, cnt_w}, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
